ss_edge_monitor: RTL and testbench

SS_EDGE_MONITOR -- requirements
Module: SS_edge_monitor

---
 rtl/ss_edge_monitor.sv | 144 ++++++++++++++
 tb/tb_ss_edge_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_edge_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ss_edge_monitor                                          |
// | Description : Multi-channel input monitor. Each channel synchronises  |
// |               a raw asynchronous input, debounces it, and reports      |
// |               qualifying filtered edges as a pulse, a sticky flag and  |
// |               a saturating event count.                                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ss_edge_monitor #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_CH-1:0]         i_signal,
  input  logic [2*NUM_CH-1:0]       i_mode,
  input  logic [DEB_W-1:0]          i_deb_len,
  input  logic [NUM_CH-1:0]         i_clr,
  output logic [NUM_CH-1:0]         o_level,
  output logic [NUM_CH-1:0]         o_pulse,
  output logic [NUM_CH-1:0]         o_sticky,
  output logic [NUM_CH*CNT_W-1:0]   o_cnt,
  output logic                      o_any
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_t;

  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    deb_state_t             state, state_nxt;
    logic [DEB_W-1:0]       dcnt, dcnt_nxt;
    logic                   f, f_nxt;
    logic                   pulse, pulse_nxt;
    logic                   sticky;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             mode;

    assign s    = sync[SYNC_STAGES-1];
    assign mode = i_mode[2*k +: 2];

    // Synchroniser chain bringing the raw input into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], i_signal[k]};
    end

    // Debounce next-state: f only follows s after L+1 consecutive mismatching
    // cycles; the >= compare lets a shrunk L release a pending change at once.
    always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      f_nxt     = f;
      case (state)
        ST_STABLE: begin
          if (s != f) begin
            if (i_deb_len == '0) begin
              f_nxt = s;
            end else begin
              dcnt_nxt  = DEB_W'(1);
              state_nxt = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (s == f) begin
            dcnt_nxt  = '0;
            state_nxt = ST_STABLE;
          end else if (dcnt >= i_deb_len) begin
            f_nxt     = s;
            dcnt_nxt  = '0;
            state_nxt = ST_STABLE;
          end else begin
            dcnt_nxt  = dcnt + DEB_W'(1);
          end
        end
        default: begin
          dcnt_nxt  = '0;
          state_nxt = ST_STABLE;
        end
      endcase
    end

    // Edge qualification against the channel mode, evaluated on the filtered value.
    always_comb begin
      pulse_nxt = 1'b0;
      case (mode)
        MODE_RISE: pulse_nxt = f_nxt & ~f;
        MODE_FALL: pulse_nxt = ~f_nxt & f;
        MODE_BOTH: pulse_nxt = f_nxt ^ f;
        default:   pulse_nxt = 1'b0;
      endcase
    end

    // Debounce state, filtered level and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= ST_STABLE;
        dcnt  <= '0;
        f     <= 1'b0;
        pulse <= 1'b0;
      end else begin
        state <= state_nxt;
        dcnt  <= dcnt_nxt;
        f     <= f_nxt;
        pulse <= pulse_nxt;
      end
    end

    // Sticky flag and saturating counter update on the same edge as the pulse,
    // so a pulse coinciding with a clear is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end else begin
        if (pulse_nxt)     sticky <= 1'b1;
        else if (i_clr[k]) sticky <= 1'b0;

        if (i_clr[k])                      cnt <= pulse_nxt ? CNT_W'(1) : '0;
        else if (pulse_nxt && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
    end

    assign o_level[k]              = f;
    assign o_pulse[k]              = pulse;
    assign o_sticky[k]             = sticky;
    assign o_cnt[k*CNT_W +: CNT_W] = cnt;
  end

  assign o_any = |o_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ss_edge_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ss_edge_monitor                                       |
// | Description : Directed self-checking bench for ss_edge_monitor.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_ss_edge_monitor;
  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_W       = 8;
  localparam int CNT_W       = 2;

  logic                    clk     = 1'b0;
  logic                    rst_n   = 1'b0;
  logic [NUM_CH-1:0]       sig     = '0;
  logic [2*NUM_CH-1:0]     mode    = '0;
  logic [DEB_W-1:0]        deb_len = '0;
  logic [NUM_CH-1:0]       clr     = '0;
  logic [NUM_CH-1:0]       level;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       sticky;
  logic [NUM_CH*CNT_W-1:0] cnt;
  logic                    any;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_seen [NUM_CH] = '{0, 0, 0, 0};
  int base;

  always #5 clk = ~clk;

  ss_edge_monitor #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_signal  (sig),
    .i_mode    (mode),
    .i_deb_len (deb_len),
    .i_clr     (clr),
    .o_level   (level),
    .o_pulse   (pulse),
    .o_sticky  (sticky),
    .o_cnt     (cnt),
    .o_any     (any)
  );

  // Running per-channel pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (pulse[k]) pulse_seen[k] <= pulse_seen[k] + 1;
  end

  function automatic logic [CNT_W-1:0] ch_cnt(input int ch);
    return cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if ({level, pulse, sticky, cnt, any} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b pls=%b stk=%b cnt=%h any=%b, expected all zero",
               level, pulse, sticky, cnt, any);
    end
    rst_n = 1'b1;
    tick(2);
    n_checks++;
    if ({level, pulse, sticky, cnt, any} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got lvl=%b pls=%b stk=%b cnt=%h any=%b, expected all zero",
               level, pulse, sticky, cnt, any);
    end
  endtask

  task automatic test_rise_l0;
    mode    = 8'b00_00_00_01;
    deb_len = 8'd0;
    sig[0]  = 1'b1;
    tick(2);
    n_checks++;
    if (pulse !== 4'b0000 || level !== 4'b0000) begin
      n_fail++;
      $display("FAIL rise_early: got pls=%b lvl=%b, expected 0000/0000", pulse, level);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0001 || level !== 4'b0001) begin
      n_fail++;
      $display("FAIL rise_edge3: got pls=%b lvl=%b, expected 0001/0001", pulse, level);
    end
    n_checks++;
    if (ch_cnt(0) !== 2'd1 || sticky !== 4'b0001 || any !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_flags: got cnt0=%0d stk=%b any=%b, expected 1/0001/1", ch_cnt(0), sticky, any);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL rise_one_cycle: got pls=%b, expected 0000", pulse);
    end
    sig[0] = 1'b0;
    tick(3);
    n_checks++;
    if (level[0] !== 1'b0 || pulse !== 4'b0000 || ch_cnt(0) !== 2'd1) begin
      n_fail++;
      $display("FAIL rise_mode_ignores_fall: got lvl0=%b pls=%b cnt0=%0d, expected 0/0000/1",
               level[0], pulse, ch_cnt(0));
    end
  endtask

  task automatic test_glitch;
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    n_checks++;
    if (sticky !== 4'b0000 || ch_cnt(0) !== 2'd0 || any !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ch0: got stk=%b cnt0=%0d any=%b, expected 0000/0/0", sticky, ch_cnt(0), any);
    end
    mode    = 8'b00_00_11_00;
    deb_len = 8'd3;
    base    = pulse_seen[1];
    sig[1]  = 1'b1;
    tick(3);
    sig[1]  = 1'b0;
    tick(8);
    n_checks++;
    if (level[1] !== 1'b0 || pulse_seen[1] !== base) begin
      n_fail++;
      $display("FAIL glitch_rejected: got lvl1=%b pulses=%0d, expected 0/%0d", level[1], pulse_seen[1], base);
    end
    sig[1] = 1'b1;
    tick(5);
    n_checks++;
    if (pulse[1] !== 1'b0 || level[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL deb_early: got pls1=%b lvl1=%b at edge 5, expected 0/0", pulse[1], level[1]);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0010 || level[1] !== 1'b1 || ch_cnt(1) !== 2'd1) begin
      n_fail++;
      $display("FAIL deb_rise_edge6: got pls=%b lvl1=%b cnt1=%0d, expected 0010/1/1", pulse, level[1], ch_cnt(1));
    end
    sig[1] = 1'b0;
    tick(6);
    n_checks++;
    if (pulse !== 4'b0010 || level[1] !== 1'b0 || ch_cnt(1) !== 2'd2) begin
      n_fail++;
      $display("FAIL deb_fall_edge6: got pls=%b lvl1=%b cnt1=%0d, expected 0010/0/2", pulse, level[1], ch_cnt(1));
    end
    n_checks++;
    if (sticky !== 4'b0010 || any !== 1'b1) begin
      n_fail++;
      $display("FAIL deb_sticky: got stk=%b any=%b, expected 0010/1", sticky, any);
    end
  endtask

  task automatic test_saturate;
    deb_len = 8'd0;
    mode    = 8'b01_00_11_00;
    for (int i = 0; i < 5; i++) begin
      sig[3] = 1'b1;
      tick(4);
      n_checks++;
      if (ch_cnt(3) !== CNT_W'((i + 1 > 3) ? 3 : i + 1)) begin
        n_fail++;
        $display("FAIL sat_count[%0d]: got %0d, expected %0d", i, ch_cnt(3), (i + 1 > 3) ? 3 : i + 1);
      end
      sig[3] = 1'b0;
      tick(4);
    end
    sig[3] = 1'b1;
    tick(2);
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    n_checks++;
    if (pulse[3] !== 1'b1 || ch_cnt(3) !== 2'd1 || sticky[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_with_clr: got pls3=%b cnt3=%0d stk3=%b, expected 1/1/1", pulse[3], ch_cnt(3), sticky[3]);
    end
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    n_checks++;
    if (ch_cnt(3) !== 2'd0 || sticky[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_only: got cnt3=%0d stk3=%b, expected 0/0", ch_cnt(3), sticky[3]);
    end
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    n_checks++;
    if (any !== 1'b0 || sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL any_cleared: got any=%b stk=%b, expected 0/0000", any, sticky);
    end
    sig[3] = 1'b0;
    tick(4);
  endtask

  task automatic test_mode_off_and_fall;
    mode    = 8'b00_00_00_00;
    deb_len = 8'd0;
    base    = pulse_seen[2];
    sig[2]  = 1'b1;
    tick(2);
    n_checks++;
    if (level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL off_level_early: got lvl2=%b, expected 0", level[2]);
    end
    tick(1);
    n_checks++;
    if (level[2] !== 1'b1 || pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL off_level_rise: got lvl2=%b pls=%b, expected 1/0000", level[2], pulse);
    end
    sig[2] = 1'b0;
    tick(3);
    n_checks++;
    if (level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL off_level_fall: got lvl2=%b, expected 0", level[2]);
    end
    tick(1);
    n_checks++;
    if (pulse_seen[2] !== base) begin
      n_fail++;
      $display("FAIL off_no_pulse: got %0d pulses, expected %0d", pulse_seen[2], base);
    end
    mode   = 8'b00_10_00_00;
    sig[2] = 1'b1;
    tick(3);
    n_checks++;
    if (level[2] !== 1'b1 || pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL fall_mode_rise: got lvl2=%b pls=%b, expected 1/0000", level[2], pulse);
    end
    sig[2] = 1'b0;
    tick(2);
    n_checks++;
    if (pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL fall_mode_early: got pls=%b, expected 0000", pulse);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0100 || level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_mode_fall: got pls=%b lvl2=%b, expected 0100/0", pulse, level[2]);
    end
    tick(2);
    n_checks++;
    if (pulse_seen[2] !== base + 1) begin
      n_fail++;
      $display("FAIL fall_mode_count: got %0d pulses, expected %0d", pulse_seen[2], base + 1);
    end
  endtask

  task automatic test_reset_cases;
    mode    = 8'b00_00_00_11;
    deb_len = 8'd0;
    rst_n   = 1'b0;
    sig[0]  = 1'b1;
    tick(2);
    n_checks++;
    if ({level, pulse, sticky, cnt, any} !== '0) begin
      n_fail++;
      $display("FAIL held_in_reset: got lvl=%b pls=%b stk=%b cnt=%h any=%b, expected all zero",
               level, pulse, sticky, cnt, any);
    end
    base  = pulse_seen[0];
    rst_n = 1'b1;
    tick(2);
    n_checks++;
    if (level[0] !== 1'b0 || pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_early: got lvl0=%b pls0=%b, expected 0/0", level[0], pulse[0]);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0001 || level[0] !== 1'b1 || ch_cnt(0) !== 2'd1) begin
      n_fail++;
      $display("FAIL release_rise: got pls=%b lvl0=%b cnt0=%0d, expected 0001/1/1", pulse, level[0], ch_cnt(0));
    end
    tick(3);
    n_checks++;
    if (pulse_seen[0] !== base + 1) begin
      n_fail++;
      $display("FAIL release_single: got %0d pulses, expected %0d", pulse_seen[0], base + 1);
    end
    rst_n  = 1'b0;
    sig[0] = 1'b0;
    tick(1);
    rst_n   = 1'b1;
    deb_len = 8'd10;
    tick(3);
    base   = pulse_seen[0];
    sig[0] = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, pulse, sticky, cnt, any} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_check: got lvl=%b pls=%b stk=%b cnt=%h any=%b, expected all zero",
               level, pulse, sticky, cnt, any);
    end
    sig[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    n_checks++;
    if (level[0] !== 1'b0 || pulse_seen[0] !== base) begin
      n_fail++;
      $display("FAIL aborted_change: got lvl0=%b pulses=%0d, expected 0/%0d", level[0], pulse_seen[0], base);
    end
    sig[0] = 1'b1;
    tick(12);
    n_checks++;
    if (pulse[0] !== 1'b0 || level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL requalify_early: got pls0=%b lvl0=%b at edge 12, expected 0/0", pulse[0], level[0]);
    end
    tick(1);
    n_checks++;
    if (pulse !== 4'b0001 || level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL requalify_edge13: got pls=%b lvl0=%b, expected 0001/1", pulse, level[0]);
    end
  endtask

  initial begin
    test_reset();
    test_rise_l0();
    test_glitch();
    test_saturate();
    test_mode_off_and_fall();
    test_reset_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
